// File: rtl/cipher_pipe_stream.sv
// cipher_pipe_stream: stall-capable Feistel-style block-cipher pipeline for the
// 64-bit packet datapath. The design has NUM_ROUNDS round stages and one output
// register, and every stage advances on a single global enable. Header words ride
// through the same stages unchanged, so word order and latency stay the same for
// header and payload words.
//
// Handshake (valid/ready): a word moves on a clock edge when the source asserts
// valid (in_wr / out_wr) and the sink asserts ready (in_rdy / out_rdy) in the same
// cycle. A source that has raised valid holds the word steady until that edge.
//
// Key updates are deferred: key_wr parks key_in in a pending buffer and blocks
// new input until the pipe is empty. Only then does the pending value replace the
// live key register, so each in-flight word finishes under the key it entered with.
module cipher_pipe_stream #(
  parameter int NUM_ROUNDS = 5,
  parameter int CTRL_W     = 8,
  parameter int CNT_W      = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [63:0]             in_data,
  input  logic [CTRL_W-1:0]       in_ctrl,
  input  logic                    in_wr,
  output logic                    in_rdy,
  input  logic                    inside_payload,
  input  logic                    mode,
  input  logic [16*NUM_ROUNDS-1:0] key_in,
  input  logic                    key_wr,
  output logic                    key_busy,
  output logic [63:0]             out_data,
  output logic [CTRL_W-1:0]       out_ctrl,
  output logic                    out_wr,
  input  logic                    out_rdy,
  output logic [CNT_W-1:0]        payload_cnt
);

  // f(x,k) = rotl16(x + k, 5)
  function automatic logic [15:0] f_mix(input logic [15:0] x, input logic [15:0] k);
    logic [15:0] s;
    s = x + k;
    return {s[10:0], s[15:11]};
  endfunction

  // One round on lanes {d3,d2,d1,d0}. Encrypt and decrypt are exact inverses,
  // so a decrypt pass that uses the reversed key order undoes an encrypt pass.
  function automatic logic [63:0] round_fn(input logic [63:0] d, input logic [15:0] k,
                                           input logic enc);
    logic [15:0] d0, d1, d2, d3;
    d0 = d[15:0];
    d1 = d[31:16];
    d2 = d[47:32];
    d3 = d[63:48];
    if (enc) return {d0 ^ f_mix(d1, k), d3, d2, d1};
    else     return {d2, d1, d0, d3 ^ f_mix(d0, k)};
  endfunction

  logic [16*NUM_ROUNDS-1:0] key_q, key_pend_q;
  logic                     busy_q;

  logic [63:0]       dat_q [NUM_ROUNDS];
  logic [63:0]       dat_d [NUM_ROUNDS];
  logic [CTRL_W-1:0] ctl_q [NUM_ROUNDS];
  logic [CTRL_W-1:0] ctl_d [NUM_ROUNDS];
  logic [NUM_ROUNDS-1:0] vld_q, vld_d;
  logic [NUM_ROUNDS-1:0] pay_q, pay_d;
  logic [NUM_ROUNDS-1:0] md_q, md_d;

  logic [63:0]       out_data_q;
  logic [CTRL_W-1:0] out_ctrl_q;
  logic              out_wr_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              en;
  logic              take;
  logic              pipe_empty;
  logic [15:0]       rk;

  assign en         = !out_wr_q || out_rdy;
  assign in_rdy     = en && !busy_q && !key_wr;
  assign take       = in_wr && in_rdy;
  assign pipe_empty = (vld_q == '0) && !out_wr_q;

  assign key_busy    = busy_q;
  assign out_data    = out_data_q;
  assign out_ctrl    = out_ctrl_q;
  assign out_wr      = out_wr_q;
  assign payload_cnt = cnt_q;

  // Next-state for the round stages: stage s applies round s to what enters it,
  // choosing the key slice by the word's own mode (forward or reversed order).
  always_comb begin
    rk = mode ? key_q[15:0] : key_q[16*(NUM_ROUNDS-1) +: 16];
    dat_d[0] = inside_payload ? round_fn(in_data, rk, mode) : in_data;
    ctl_d[0] = in_ctrl;
    vld_d    = '0;
    pay_d    = '0;
    md_d     = '0;
    vld_d[0] = take;
    pay_d[0] = inside_payload;
    md_d[0]  = mode;
    for (int s = 1; s < NUM_ROUNDS; s++) begin
      rk = md_q[s-1] ? key_q[16*s +: 16] : key_q[16*(NUM_ROUNDS-1-s) +: 16];
      dat_d[s] = pay_q[s-1] ? round_fn(dat_q[s-1], rk, md_q[s-1]) : dat_q[s-1];
      ctl_d[s] = ctl_q[s-1];
      vld_d[s] = vld_q[s-1];
      pay_d[s] = pay_q[s-1];
      md_d[s]  = md_q[s-1];
    end
  end

  // Round-stage and output registers: all advance together on en, all hold otherwise.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int s = 0; s < NUM_ROUNDS; s++) begin
        dat_q[s] <= '0;
        ctl_q[s] <= '0;
      end
      vld_q      <= '0;
      pay_q      <= '0;
      md_q       <= '0;
      out_data_q <= '0;
      out_ctrl_q <= '0;
      out_wr_q   <= 1'b0;
    end else if (en) begin
      for (int s = 0; s < NUM_ROUNDS; s++) begin
        dat_q[s] <= dat_d[s];
        ctl_q[s] <= ctl_d[s];
      end
      vld_q      <= vld_d;
      pay_q      <= pay_d;
      md_q       <= md_d;
      out_data_q <= dat_q[NUM_ROUNDS-1];
      out_ctrl_q <= ctl_q[NUM_ROUNDS-1];
      out_wr_q   <= vld_q[NUM_ROUNDS-1];
    end
  end

  // Key update: a new request always refreshes the pending buffer. The live key
  // changes only once the pipe is empty and no fresh request arrives in that cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      key_q      <= '0;
      key_pend_q <= '0;
      busy_q     <= 1'b0;
    end else if (key_wr) begin
      key_pend_q <= key_in;
      busy_q     <= 1'b1;
    end else if (busy_q && pipe_empty) begin
      key_q  <= key_pend_q;
      busy_q <= 1'b0;
    end
  end

  // Payload word counter, counted at input acceptance and wrapping freely.
  always_ff @(posedge clk) begin
    if (!reset_n)                     cnt_q <= '0;
    else if (take && inside_payload)  cnt_q <= cnt_q + CNT_W'(1);
  end

endmodule

// File: tb/tb_cipher_pipe_stream.sv
// Bench for cipher_pipe_stream: randomized stream traffic scored against a lane-level
// reference model, plus directed key-update, stall, reset and counter-wrap cases.
// A second, single-round instance checks the known-answer vector.
module tb_cipher_pipe_stream;
  localparam int NR   = 5;
  localparam int CW   = 8;
  localparam int KW   = 16 * NR;
  localparam int CNTW = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic [63:0]   in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic          in_wr = 1'b0, in_rdy, inside_payload = 1'b0, mode = 1'b0;
  logic [KW-1:0] key_in = '0;
  logic          key_wr = 1'b0, key_busy;
  logic [63:0]   out_data;
  logic [CW-1:0] out_ctrl;
  logic          out_wr;
  logic          out_rdy = 1'b1;
  logic [CNTW-1:0] payload_cnt;

  cipher_pipe_stream #(.NUM_ROUNDS(NR), .CTRL_W(CW), .CNT_W(CNTW)) dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr),
    .in_rdy(in_rdy), .inside_payload(inside_payload), .mode(mode), .key_in(key_in),
    .key_wr(key_wr), .key_busy(key_busy), .out_data(out_data), .out_ctrl(out_ctrl),
    .out_wr(out_wr), .out_rdy(out_rdy), .payload_cnt(payload_cnt));

  // single-round instance
  logic [63:0] s_in_data = '0;
  logic [7:0]  s_in_ctrl = '0;
  logic        s_in_wr = 1'b0, s_in_rdy;
  logic [15:0] s_key_in = '0;
  logic        s_key_wr = 1'b0, s_key_busy;
  logic [63:0] s_out_data;
  logic [7:0]  s_out_ctrl;
  logic        s_out_wr;
  logic        s_out_rdy = 1'b1;
  logic [31:0] s_payload_cnt;

  cipher_pipe_stream #(.NUM_ROUNDS(1), .CTRL_W(8), .CNT_W(32)) dut1 (
    .clk(clk), .reset_n(reset_n), .in_data(s_in_data), .in_ctrl(s_in_ctrl), .in_wr(s_in_wr),
    .in_rdy(s_in_rdy), .inside_payload(1'b1), .mode(1'b1), .key_in(s_key_in),
    .key_wr(s_key_wr), .key_busy(s_key_busy), .out_data(s_out_data), .out_ctrl(s_out_ctrl),
    .out_wr(s_out_wr), .out_rdy(s_out_rdy), .payload_cnt(s_payload_cnt));

  int n_chk = 0;
  int n_fail = 0;
  int n_out = 0;
  logic [CW+63:0]  exp_q[$];
  logic [63:0]     got_q[$];
  logic [KW-1:0]   model_key = '0;
  logic [CNTW-1:0] exp_cnt = '0;
  bit rand_rdy = 0;
  bit force_rdy = 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // ---------------- reference model (lane arithmetic straight from the round rules)
  function automatic logic [15:0] rotl5(input logic [15:0] v);
    return (v << 5) | (v >> 11);
  endfunction

  function automatic logic [63:0] model_cipher(input logic [63:0] x, input logic [KW-1:0] key,
                                               input bit enc);
    logic [15:0] l[4];
    logic [15:0] k, s, t;
    for (int i = 0; i < 4; i++) l[i] = x[16*i +: 16];
    for (int r = 0; r < NR; r++) begin
      k = enc ? key[16*r +: 16] : key[16*(NR-1-r) +: 16];
      if (enc) begin
        s = l[1] + k;
        t = l[0] ^ rotl5(s);
        l[0] = l[1]; l[1] = l[2]; l[2] = l[3]; l[3] = t;
      end else begin
        s = l[0] + k;
        t = l[3] ^ rotl5(s);
        l[3] = l[2]; l[2] = l[1]; l[1] = l[0]; l[0] = t;
      end
    end
    return {l[3], l[2], l[1], l[0]};
  endfunction

  // ---------------- downstream ready driver
  always @(negedge clk) out_rdy = rand_rdy ? ($urandom_range(0, 3) != 0) : force_rdy;

  // ---------------- monitor / scoreboard
  bit stalled = 0;
  logic [CW+63:0] held;
  always @(negedge clk) begin
    #2;
    if (reset_n && out_wr) begin
      if (stalled) chk("stall_stable", {out_ctrl, out_data}, held);
      if (out_rdy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", {out_ctrl, out_data}, '1);
        end else begin
          chk("out_word", {out_ctrl, out_data}, exp_q.pop_front());
        end
        got_q.push_back(out_data);
        n_out++;
        stalled = 0;
      end else begin
        stalled = 1;
        held = {out_ctrl, out_data};
      end
    end else begin
      stalled = 0;
    end
  end

  // ---------------- driver tasks
  task automatic send(input logic [63:0] d, input logic [CW-1:0] c, input bit pay,
                      input bit enc, input bit have_want, input logic [63:0] want);
    int waited = 0;
    @(negedge clk);
    in_data = d; in_ctrl = c; inside_payload = pay; mode = enc; in_wr = 1'b1;
    #1;
    while (!in_rdy && waited < 200) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!in_rdy) begin
      chk("send_timeout", 0, 1);
    end else begin
      if (have_want)  exp_q.push_back({c, want});
      else if (pay)   exp_q.push_back({c, model_cipher(d, model_key, enc)});
      else            exp_q.push_back({c, d});
      if (pay) exp_cnt++;
    end
    @(posedge clk);
    #1 in_wr = 1'b0;
  endtask

  task automatic load_key(input logic [KW-1:0] k);
    @(negedge clk);
    key_in = k; key_wr = 1'b1;
    @(negedge clk);
    key_wr = 1'b0;
    model_key = k;
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 1000) begin
      @(negedge clk);
      g++;
    end
    chk("drain_timeout", exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  function automatic logic [KW-1:0] rand_key();
    logic [KW-1:0] k;
    for (int i = 0; i < NR; i++) k[16*i +: 16] = 16'($urandom);
    return k;
  endfunction

  logic [63:0]   org_a[100];
  logic [CW-1:0] ctl_a[100];
  logic [63:0]   enc_a[100];

  initial begin
    // ---- reset values
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_out_wr", out_wr, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_cnt", payload_cnt, 0);
    chk("rst_key_busy", key_busy, 0);
    reset_n = 1'b1;

    // ---- single-round known-answer vector, out_wr two cycles after transfer
    @(negedge clk); s_key_in = 16'h0001; s_key_wr = 1'b1;
    @(negedge clk); s_key_wr = 1'b0;
    repeat (2) @(negedge clk);
    s_in_data = 64'h0003_0002_0001_0000; s_in_ctrl = 8'hA5; s_in_wr = 1'b1;
    #1 chk("kat_in_rdy", s_in_rdy, 1);
    @(negedge clk); s_in_wr = 1'b0;
    #2 chk("kat_not_yet", s_out_wr, 0);
    @(negedge clk); #2;
    chk("kat_out_wr", s_out_wr, 1);
    chk("kat_out_data", s_out_data, 64'h0040_0003_0002_0001);
    chk("kat_out_ctrl", s_out_ctrl, 8'hA5);
    chk("kat_cnt", s_payload_cnt, 1);
    chk("kat_key_busy", s_key_busy, 0);

    // ---- round trip: 100 encrypted, then fed back decrypted, random backpressure
    load_key(rand_key());
    got_q.delete();
    rand_rdy = 1;
    for (int i = 0; i < 100; i++) begin
      org_a[i] = {$urandom, $urandom};
      ctl_a[i] = CW'($urandom);
      send(org_a[i], ctl_a[i], 1, 1, 0, '0);
    end
    drain();
    chk("enc_count", got_q.size(), 100);
    for (int i = 0; i < 100; i++) enc_a[i] = (got_q.size() != 0) ? got_q.pop_front() : '0;
    for (int i = 0; i < 100; i++) send(enc_a[i], ctl_a[i], 1, 0, 1, org_a[i]);
    drain();
    rand_rdy = 0;
    chk("cnt_200", payload_cnt, 8'd200);

    // ---- header/payload/header with a 7-cycle downstream stall
    force_rdy = 0;
    send(64'hDEAD_BEEF_0123_4567, 8'h11, 0, 1, 0, '0);
    send(64'h0F0F_F0F0_1234_5678, 8'h22, 1, 1, 0, '0);
    send(64'hCAFE_F00D_8899_AABB, 8'h33, 0, 0, 0, '0);
    begin
      int st = 0;
      int g = 0;
      while (st < 7 && g < 40) begin
        @(negedge clk); #1;
        if (out_wr) begin
          chk("stall_in_rdy", in_rdy, 0);
          st++;
        end
        g++;
      end
      chk("stall_reached", st, 7);
    end
    force_rdy = 1;
    drain();

    // ---- key update with 3 words in flight
    for (int i = 0; i < 3; i++) send({$urandom, $urandom}, CW'(i), 1, i[0], 0, '0);
    begin
      logic [KW-1:0] k;
      int target;
      int g = 0;
      k = rand_key();
      @(negedge clk); key_in = k; key_wr = 1'b1;
      #1 chk("kw_in_rdy", in_rdy, 0);
      target = n_out + exp_q.size();
      @(negedge clk); key_wr = 1'b0; model_key = k;
      #1;
      while (n_out < target && g < 40) begin
        chk("drain_busy", key_busy, 1);
        chk("drain_in_rdy", in_rdy, 0);
        @(negedge clk); #1;
        g++;
      end
      chk("drain_done", n_out, target);
      chk("busy_after_empty", key_busy, 1);
      @(negedge clk); #1;
      chk("busy_cleared", key_busy, 0);
    end
    send({$urandom, $urandom}, 8'h44, 1, 1, 0, '0);
    drain();

    // ---- key_wr and in_wr together on an empty pipe
    begin
      logic [KW-1:0] k;
      logic [63:0] d;
      k = rand_key();
      d = {$urandom, $urandom};
      @(negedge clk);
      in_data = d; in_ctrl = 8'h55; inside_payload = 1'b1; mode = 1'b1; in_wr = 1'b1;
      key_in = k; key_wr = 1'b1;
      #1 chk("same_cycle_rdy", in_rdy, 0);
      @(negedge clk); key_wr = 1'b0; model_key = k;
      #1 chk("same_cycle_busy", key_busy, 1);
      chk("same_cycle_rdy2", in_rdy, 0);
      @(negedge clk); #1;
      chk("same_cycle_loaded", key_busy, 0);
      chk("retry_rdy", in_rdy, 1);
      exp_q.push_back({8'h55, model_cipher(d, model_key, 1)});
      exp_cnt++;
      @(posedge clk); #1 in_wr = 1'b0;
    end
    drain();

    // ---- counter wrap
    rand_rdy = 1;
    while (exp_cnt != 8'hFF) send({$urandom, $urandom}, CW'($urandom), 1, $urandom_range(0, 1), 0, '0);
    drain();
    chk("cnt_ff", payload_cnt, 8'hFF);
    send({$urandom, $urandom}, 8'h66, 1, 1, 0, '0);
    drain();
    rand_rdy = 0;
    chk("cnt_wrap", payload_cnt, 8'h00);

    // ---- reset with a stalled full pipe and a pending key
    force_rdy = 0;
    for (int i = 0; i < 3; i++) send({$urandom, $urandom}, CW'(i), 1, 1, 0, '0);
    begin
      int g = 0;
      while (!out_wr && g < 30) begin
        @(negedge clk); g++;
      end
      chk("fill_out_wr", out_wr, 1);
    end
    @(negedge clk); key_in = rand_key(); key_wr = 1'b1;
    @(negedge clk); key_wr = 1'b0; reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    exp_q.delete();
    model_key = '0;
    exp_cnt = '0;
    #1;
    chk("mid_rst_out_wr", out_wr, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_cnt", payload_cnt, 0);
    chk("mid_rst_busy", key_busy, 0);
    force_rdy = 1;
    send(64'h1111_2222_3333_4444, 8'h77, 1, 1, 0, '0);
    drain();
    chk("post_rst_cnt", payload_cnt, 1);

    chk("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
